// File: rtl/arbiter_8ch.sv
// ---------------------------------------------------------------------------
// arbiter_8ch
// Eight-requester arbiter. It offers either fixed priority (req[7] wins) or
// round-robin selection. A grant is held until the holder signals done,
// drops its request, or runs out its TIMEOUT budget. Every grant is followed
// by one GAP cycle, so two grants are never back to back.
//
// Parameters
//    TIMEOUT     : maximum number of cycles a grant is held (1..15)
//
// Ports
//    clk         : sole clock, rising edge
//    rst         : synchronous active-high reset
//    en          : arbiter enable
//    mode        : 0 = fixed priority, 1 = round-robin (sampled in IDLE only)
//    req[7:0]    : one request line per requester
//    done        : release strobe from the current grant holder
//    gnt[7:0]    : registered one-hot grant
//    gnt_id[2:0] : registered binary index of the granted requester
//    gnt_valid   : registered, high whenever gnt is nonzero
//    timeout_err : one-cycle pulse when a grant is revoked by timeout only
// ---------------------------------------------------------------------------
module arbiter_8ch #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       mode,
   input  logic [7:0] req,
   input  logic       done,
   output logic [7:0] gnt,
   output logic [2:0] gnt_id,
   output logic       gnt_valid,
   output logic       timeout_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   // The hold counter starts at zero on the granting edge, so the grant is
   // revoked on the edge where it reaches TIMEOUT-1; that keeps gnt visible
   // for exactly TIMEOUT cycles.
   localparam logic [3:0] HOLD_MAX = 4'(TIMEOUT - 1);

   state_t     state;
   state_t     nextState;
   logic [2:0] ptr;
   logic [3:0] holdCnt;

   logic [7:0] nextGnt;
   logic [2:0] nextGntId;
   logic       nextGntValid;
   logic       nextTimeoutErr;
   logic [2:0] nextPtr;
   logic [3:0] nextHoldCnt;

   logic [2:0] fixedWinner;
   logic [2:0] rrWinner;
   logic [2:0] rrIdx;
   logic [2:0] winner;
   logic       relDone;
   logic       relDrop;
   logic       relTimeout;

   // Candidate winners for both modes. The fixed scan keeps the last
   // (highest) set bit. The round-robin scan walks the offsets downward so
   // the smallest offset from ptr is the one left standing; the 3-bit add
   // gives the 7->0 wrap for free.
   always_comb begin
      fixedWinner = '0;
      rrWinner    = '0;
      rrIdx       = '0;
      for (int i = 0; i < 8; i++) begin
         if (req[i]) fixedWinner = 3'(i);
      end
      for (int i = 7; i >= 0; i--) begin
         rrIdx = ptr + 3'(i);
         if (req[rrIdx]) rrWinner = rrIdx;
      end
   end

   // Next-state and next-output logic. Everything defaults to "hold", with
   // timeout_err defaulting low so it can only ever be a single-cycle pulse.
   // Within GRANT, a dropped enable outranks the normal release conditions
   // and deliberately leaves ptr alone.
   always_comb begin
      nextState      = state;
      nextGnt        = gnt;
      nextGntId      = gnt_id;
      nextGntValid   = gnt_valid;
      nextTimeoutErr = 1'b0;
      nextPtr        = ptr;
      nextHoldCnt    = holdCnt;
      winner         = mode ? rrWinner : fixedWinner;
      relDone        = done;
      relDrop        = ~req[gnt_id];
      relTimeout     = (holdCnt == HOLD_MAX);

      case (state)
         IDLE: begin
            if (en && (req != 8'd0)) begin
               nextState    = GRANT;
               nextGnt      = 8'(1) << winner;
               nextGntId    = winner;
               nextGntValid = 1'b1;
               nextHoldCnt  = '0;
            end
         end

         GRANT: begin
            if (!en) begin
               nextState    = IDLE;
               nextGnt      = '0;
               nextGntId    = '0;
               nextGntValid = 1'b0;
               nextHoldCnt  = '0;
            end else if (relDone || relDrop || relTimeout) begin
               nextState      = GAP;
               nextGnt        = '0;
               nextGntId      = '0;
               nextGntValid   = 1'b0;
               nextHoldCnt    = '0;
               nextPtr        = gnt_id + 3'd1;
               nextTimeoutErr = relTimeout && !relDone && !relDrop;
            end else begin
               nextHoldCnt = holdCnt + 4'd1;
            end
         end

         GAP: begin
            nextState = IDLE;
         end

         default: begin
            nextState    = IDLE;
            nextGnt      = '0;
            nextGntId    = '0;
            nextGntValid = 1'b0;
            nextHoldCnt  = '0;
         end
      endcase
   end

   // State and output registers. Reset wins over everything, including an
   // active grant, and never raises timeout_err.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         gnt         <= '0;
         gnt_id      <= '0;
         gnt_valid   <= 1'b0;
         timeout_err <= 1'b0;
         ptr         <= '0;
         holdCnt     <= '0;
      end else begin
         state       <= nextState;
         gnt         <= nextGnt;
         gnt_id      <= nextGntId;
         gnt_valid   <= nextGntValid;
         timeout_err <= nextTimeoutErr;
         ptr         <= nextPtr;
         holdCnt     <= nextHoldCnt;
      end
   end

endmodule

// File: tb/tb_arbiter_8ch.sv
// ---------------------------------------------------------------------------
// tb_arbiter_8ch
// Self-checking bench for arbiter_8ch (TIMEOUT = 4). A behavioural model
// tracks who holds the grant, how long it has been held, the cool-down cycle
// and the round-robin start point, and predicts every output after each
// edge. Directed scenarios are followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_arbiter_8ch;

   localparam int TO = 4;

   logic       clk;
   logic       rst;
   logic       en;
   logic       mode;
   logic [7:0] req;
   logic       done;
   logic [7:0] gnt;
   logic [2:0] gnt_id;
   logic       gnt_valid;
   logic       timeout_err;

   int checkCount = 0;
   int passCount  = 0;

   // Model of the arbiter: holder is the granted requester (-1 when none),
   // age is how many cycles the grant has been visible, cool marks the
   // single dead cycle after a release.
   int holder    = -1;
   int age       = 0;
   bit cool      = 1'b0;
   int rrStart   = 0;
   bit expTerr   = 1'b0;

   arbiter_8ch #(.TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .mode       (mode),
      .req        (req),
      .done       (done),
      .gnt        (gnt),
      .gnt_id     (gnt_id),
      .gnt_valid  (gnt_valid),
      .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts the check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
   endtask

   // Winner chosen from the rules: highest set bit in fixed mode, first set
   // bit walking upward from rrStart (with wrap) in round-robin mode.
   function automatic int pickWinner(input bit m, input logic [7:0] r, input int start);
      if (!m) begin
         for (int i = 7; i >= 0; i--) if (r[i]) return i;
      end else begin
         for (int k = 0; k < 8; k++) if (r[(start + k) % 8]) return (start + k) % 8;
      end
      return -1;
   endfunction

   // Advance the model by one clock edge using the inputs that were applied.
   task automatic modelStep(input bit r, input bit e, input bit m,
                            input logic [7:0] q, input bit d);
      bit byDone, byDrop, byTime;
      expTerr = 1'b0;
      if (r) begin
         holder  = -1;
         age     = 0;
         cool    = 1'b0;
         rrStart = 0;
      end else if (holder >= 0) begin
         if (!e) begin
            holder = -1;
            age    = 0;
            cool   = 1'b0;
         end else begin
            byDone = d;
            byDrop = !q[holder];
            byTime = (age == TO);
            if (byDone || byDrop || byTime) begin
               rrStart = (holder + 1) % 8;
               holder  = -1;
               age     = 0;
               cool    = 1'b1;
               expTerr = byTime && !byDone && !byDrop;
            end else begin
               age++;
            end
         end
      end else if (cool) begin
         cool = 1'b0;
      end else if (e && q != 8'd0) begin
         holder = pickWinner(m, q, rrStart);
         age    = 1;
      end
   endtask

   // Drive one cycle of inputs, clock it, update the model and compare.
   task automatic applyStimulus(input bit r, input bit e, input bit m,
                                input logic [7:0] q, input bit d);
      rst  = r;
      en   = e;
      mode = m;
      req  = q;
      done = d;
      @(posedge clk);
      modelStep(r, e, m, q, d);
      #1;
      checkOutput("gnt",         32'(gnt),         (holder >= 0) ? 32'(1) << holder : 32'd0);
      checkOutput("gnt_id",      32'(gnt_id),      (holder >= 0) ? 32'(holder) : 32'd0);
      checkOutput("gnt_valid",   32'(gnt_valid),   32'(holder >= 0));
      checkOutput("timeout_err", 32'(timeout_err), 32'(expTerr));
   endtask

   initial begin
      rst  = 1'b1;
      en   = 1'b0;
      mode = 1'b0;
      req  = '0;
      done = 1'b0;

      // Reset state.
      applyStimulus(1, 0, 0, 8'h00, 0);
      applyStimulus(1, 1, 1, 8'hFF, 1);
      checkOutput("resetGnt", 32'(gnt), 32'd0);

      // Fixed priority: first grant right after reset, then release and gap.
      applyStimulus(0, 1, 0, 8'hA6, 0);
      checkOutput("fixedWin", 32'(gnt), 32'h80);
      checkOutput("fixedId", 32'(gnt_id), 32'd7);
      applyStimulus(0, 1, 0, 8'hA6, 1);
      checkOutput("fixedRel", 32'(gnt), 32'd0);
      applyStimulus(0, 1, 0, 8'hA6, 0);
      checkOutput("gapCycle", 32'(gnt_valid), 32'd0);
      applyStimulus(0, 1, 0, 8'hA6, 0);
      checkOutput("fixedRegrant", 32'(gnt_id), 32'd7);

      // Round-robin fairness: each holder keeps the grant two cycles.
      applyStimulus(1, 0, 0, 8'h00, 0);
      for (int k = 0; k < 9; k++) begin
         applyStimulus(0, 1, 1, 8'hFF, 0);
         checkOutput("rrSeq", 32'(gnt_id), 32'(k % 8));
         applyStimulus(0, 1, 1, 8'hFF, 0);
         applyStimulus(0, 1, 1, 8'hFF, 1);
         applyStimulus(0, 1, 1, 8'hFF, 0);
      end

      // Timeout with req held, then re-grant, then done on the timeout edge.
      applyStimulus(1, 0, 0, 8'h00, 0);
      applyStimulus(0, 1, 0, 8'h08, 0);
      checkOutput("toGrant", 32'(gnt_id), 32'd3);
      for (int k = 0; k < 3; k++) applyStimulus(0, 1, 0, 8'h08, 0);
      checkOutput("toStillHeld", 32'(gnt), 32'h08);
      applyStimulus(0, 1, 0, 8'h08, 0);
      checkOutput("toPulse", 32'(timeout_err), 32'd1);
      checkOutput("toClear", 32'(gnt), 32'd0);
      applyStimulus(0, 1, 0, 8'h08, 0);
      checkOutput("toPulseEnd", 32'(timeout_err), 32'd0);
      applyStimulus(0, 1, 0, 8'h08, 0);
      checkOutput("toRegrant", 32'(gnt_id), 32'd3);
      for (int k = 0; k < 3; k++) applyStimulus(0, 1, 0, 8'h08, 0);
      applyStimulus(0, 1, 0, 8'h08, 1);
      checkOutput("toWithDone", 32'(timeout_err), 32'd0);
      checkOutput("toWithDoneGnt", 32'(gnt), 32'd0);

      // Request drop and wrap: bring ptr to 6, grant 6, drop it, wrap to 0.
      applyStimulus(1, 0, 0, 8'h00, 0);
      applyStimulus(0, 1, 1, 8'h20, 0);
      applyStimulus(0, 1, 1, 8'h20, 1);
      applyStimulus(0, 1, 1, 8'h41, 0);
      applyStimulus(0, 1, 1, 8'h41, 0);
      checkOutput("dropGrant", 32'(gnt_id), 32'd6);
      applyStimulus(0, 1, 1, 8'h01, 0);
      checkOutput("dropRel", 32'(gnt_valid), 32'd0);
      applyStimulus(0, 1, 1, 8'h01, 0);
      applyStimulus(0, 1, 1, 8'h01, 0);
      checkOutput("wrapGnt", 32'(gnt), 32'h01);

      // Reset mid-grant clears outputs and ptr.
      applyStimulus(1, 0, 0, 8'h00, 0);
      applyStimulus(0, 1, 1, 8'h08, 0);
      applyStimulus(0, 1, 1, 8'h08, 1);
      applyStimulus(0, 1, 1, 8'h08, 0);
      applyStimulus(0, 1, 1, 8'h08, 0);
      checkOutput("preRstGrant", 32'(gnt_id), 32'd3);
      applyStimulus(1, 1, 1, 8'h08, 0);
      checkOutput("rstGnt", 32'(gnt), 32'd0);
      checkOutput("rstTerr", 32'(timeout_err), 32'd0);
      applyStimulus(0, 1, 1, 8'hFF, 0);
      checkOutput("rstPtr", 32'(gnt_id), 32'd0);

      // Enable dropped mid-grant: grant clears, ptr is kept.
      applyStimulus(1, 0, 0, 8'h00, 0);
      applyStimulus(0, 1, 1, 8'h08, 0);
      applyStimulus(0, 1, 1, 8'h08, 1);
      applyStimulus(0, 1, 1, 8'hFF, 0);
      applyStimulus(0, 1, 1, 8'hFF, 0);
      checkOutput("enGrant", 32'(gnt_id), 32'd4);
      applyStimulus(0, 0, 1, 8'hFF, 0);
      checkOutput("enOffGnt", 32'(gnt), 32'd0);
      applyStimulus(0, 0, 1, 8'hFF, 0);
      checkOutput("enOffIdle", 32'(gnt_valid), 32'd0);
      applyStimulus(0, 1, 1, 8'hFF, 0);
      checkOutput("enOffPtr", 32'(gnt_id), 32'd4);

      // Randomized run against the model.
      begin
         logic [7:0] rq;
         rq = 8'($urandom);
         for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 3) == 0) rq = 8'($urandom) & 8'($urandom);
            applyStimulus($urandom_range(0, 63) == 0,
                          $urandom_range(0, 7) != 0,
                          1'($urandom),
                          rq,
                          $urandom_range(0, 5) == 0);
         end
      end

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
